// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_send transmitter among 4 byte sources.
// Optional macro UART_ARB_PRIO0_EN: requester 0 wins outright, 1..3 rotate among themselves.
module uart_tx_arbiter #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned UART_BPS     = 9600,
  parameter int unsigned START_HOLD   = 4,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic [1:0]  grant_id
);

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned BPS_CNT      = CLK_FREQ / UART_BPS;
  localparam int unsigned FRAME_CYCLES = 10 * BPS_CNT + GUARD_CYCLES;
  localparam int unsigned FRAME_W_MIN  = $clog2(FRAME_CYCLES + 1);
  localparam int unsigned FRAME_W      = (FRAME_W_MIN > 20) ? FRAME_W_MIN : 20;
  localparam int unsigned HOLD_W       = $clog2(START_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [1:0] win_c;
  logic       win_vld_c;
  logic       hold_done_c;
  logic       frame_done_c;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    return base + 2'(k);
  endfunction

  // Winner search starting at rr_ptr, wrapping modulo 4.
  always_comb begin
    win_c     = 2'd0;
    win_vld_c = 1'b0;
`ifdef UART_ARB_PRIO0_EN
    if (req_valid[0]) begin
      win_vld_c = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_vld_c && (rr_idx(rr_ptr_q, k) != 2'd0) && req_valid[rr_idx(rr_ptr_q, k)]) begin
          win_c     = rr_idx(rr_ptr_q, k);
          win_vld_c = 1'b1;
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld_c && req_valid[rr_idx(rr_ptr_q, k)]) begin
        win_c     = rr_idx(rr_ptr_q, k);
        win_vld_c = 1'b1;
      end
    end
`endif
  end

  assign hold_done_c  = (hold_cnt_q == HOLD_W'(START_HOLD - 1));
  assign frame_done_c = (frame_cnt_q == FRAME_W'(FRAME_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_vld_c)    state_d = ST_START;
      ST_START: if (hold_done_c)  state_d = ST_WAIT;
      ST_WAIT:  if (frame_done_c) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic; req_ready is the only combinational output.
  always_comb begin
    req_ready   = 4'b0000;
    tx_data_d   = tx_data_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_c) begin
          req_ready  = rst_n ? (4'b0001 << win_c) : 4'b0000;
          tx_data_d  = req_data[{win_c, 3'b000} +: 8];
          grant_id_d = win_c;
          hold_cnt_d = '0;
`ifdef UART_ARB_PRIO0_EN
          if (win_c != 2'd0) rr_ptr_d = win_c + 2'd1;
`else
          rr_ptr_d = win_c + 2'd1;
`endif
        end
      end
      ST_START: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_done_c) frame_cnt_d = '0;
      end
      ST_WAIT: begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
      default: ;
    endcase
    tx_start_d = (state_d == ST_START);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      grant_id_q  <= 2'd0;
      rr_ptr_q    <= 2'd0;
      hold_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences and a random run
// against a frame-age reference model.
module tb_uart_tx_arbiter;

  localparam int CLK_FREQ   = 1000;
  localparam int UART_BPS   = 100;
  localparam int START_HOLD = 4;
  localparam int GUARD      = 16;
  localparam int BUSY_LEN   = START_HOLD + 10 * (CLK_FREQ / UART_BPS) + GUARD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(
    .CLK_FREQ    (CLK_FREQ),
    .UART_BPS    (UART_BPS),
    .START_HOLD  (START_HOLD),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a frame is an age counter since acceptance.
  bit         m_idle = 1'b1;
  int         m_age  = 0;
  int         m_rr   = 0;
  int         m_gid  = 0;
  logic [7:0] m_data = 8'h00;

  logic [3:0] last_ready;
  logic       last_busy;
  logic       last_start;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    m_idle = 1'b1;
    m_age  = 0;
    m_rr   = 0;
    m_gid  = 0;
    m_data = 8'h00;
  endfunction

  function automatic int m_winner(input logic [3:0] v);
`ifdef UART_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_rr + k) % 4;
      if (i != 0 && v[i]) return i;
    end
`else
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_rr + k) % 4;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: compare at negedge against the model, advance model at posedge.
  task automatic cycle();
    int w;
    logic [3:0] exp_rdy;
    @(negedge clk);
    w = m_winner(req_valid);
    exp_rdy = 4'b0000;
    if (m_idle && w >= 0) exp_rdy[w] = 1'b1;
    last_ready = req_ready;
    last_busy  = busy;
    last_start = tx_start;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(!m_idle));
    chk("tx_start", 32'(tx_start), 32'(!m_idle && (m_age < START_HOLD)));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    @(posedge clk);
    if (m_idle) begin
      if (w >= 0) begin
        m_idle = 1'b0;
        m_age  = 0;
        m_gid  = w;
        m_data = req_data[8*w +: 8];
`ifdef UART_ARB_PRIO0_EN
        if (w != 0) m_rr = (w + 1) % 4;
`else
        m_rr = (w + 1) % 4;
`endif
      end
    end else begin
      m_age++;
      if (m_age >= BUSY_LEN) m_idle = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b0000;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 400; c++) begin
      if (m_idle) break;
      cycle();
    end
    chk("drain_idle", 32'(m_idle), 32'd1);
  endtask

  // Frame-level properties: spacing of tx_start rises and tx_data stability while busy.
  int         last_rise  = -1000;
  logic       prev_start = 1'b0;
  logic       prev_busy  = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_rise  = -1000;
      prev_start = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (tx_start && !prev_start) begin
        n_checks++;
        if (cyc - last_rise < BUSY_LEN + 1) begin
          n_fail++;
          $display("FAIL start_spacing: actual=%0d expected>=%0d (cycle %0d)", cyc - last_rise, BUSY_LEN + 1, cyc);
        end
        last_rise = cyc;
      end
      if (busy && prev_busy) begin
        n_checks++;
        if (tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL data_stable: actual=%0h expected=%0h (cycle %0d)", tx_data, prev_data, cyc);
        end
      end
      prev_start = tx_start;
      prev_busy  = busy;
      prev_data  = tx_data;
    end
  end

  typedef struct {
    logic [3:0] valid;
    int         gid_rr;
    int         gid_p0;
  } vec_t;

  vec_t vecs[6];
  int   exp_seq[9];

  initial begin
    int g, nb, ns, n_acc, since, nrdy, nst, nbusy;
    logic [31:0] d;
    logic [3:0] exp1h;

    vecs[0] = '{4'b0010, 1, 1};
    vecs[1] = '{4'b0011, 0, 0};
    vecs[2] = '{4'b1111, 1, 0};
    vecs[3] = '{4'b1001, 3, 0};
    vecs[4] = '{4'b1100, 2, 2};
    vecs[5] = '{4'b0111, 0, 0};
`ifdef UART_ARB_PRIO0_EN
    exp_seq = '{0, 0, 0, 0, 0, 1, 2, 3, 1};
`else
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
`endif

    // Reset values, with requests present to show req_ready stays low.
    #1;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    req_valid = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();

    // Vector table: one frame per entry.
    for (int i = 0; i < 6; i++) begin
`ifdef UART_ARB_PRIO0_EN
      g = vecs[i].gid_p0;
`else
      g = vecs[i].gid_rr;
`endif
      d = $urandom;
      if (i == 0) d[15:8] = 8'hA5;
      req_data  = d;
      req_valid = vecs[i].valid;
      cycle();
      exp1h = 4'b0000;
      exp1h[g] = 1'b1;
      chk("vec_ready", 32'(last_ready), 32'(exp1h));
      chk("vec_grant", 32'(grant_id), 32'(g));
      chk("vec_data", 32'(tx_data), 32'(d[8*g +: 8]));
      chk("vec_start", 32'(tx_start), 32'd1);
      chk("vec_busy", 32'(busy), 32'd1);
      req_valid = 4'b0000;
      req_data  = $urandom;
      nb = 0;
      ns = 0;
      for (int c = 0; c < 400; c++) begin
        cycle();
        if (last_start) ns++;
        if (!last_busy) break;
        nb++;
      end
      chk("vec_busy_len", 32'(nb), 32'(BUSY_LEN));
      chk("vec_start_len", 32'(ns), 32'(START_HOLD));
    end

    // All four continuously valid, then requester 0 drops out.
    do_reset();
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    n_acc = 0;
    since = 0;
    for (int c = 0; c < 2000; c++) begin
      if (n_acc >= 9) break;
      cycle();
      since++;
      if (last_ready != 4'b0000) begin
        chk("seq_grant", 32'(oh_idx(last_ready)), 32'(exp_seq[n_acc]));
        chk("seq_data", 32'(tx_data), 32'(32'h10 + 32'(exp_seq[n_acc])));
        if (n_acc > 0) chk("seq_spacing", 32'(since), 32'(BUSY_LEN + 1));
        since = 0;
        n_acc++;
        if (n_acc == 5) req_valid = 4'b1110;
      end
    end
    chk("seq_count", 32'(n_acc), 32'd9);
    req_valid = 4'b0000;
    drain();

    // Request pulsed during WAIT and withdrawn before IDLE is ignored.
    req_data  = $urandom;
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0000;
    for (int c = 0; c < 40; c++) cycle();
    nrdy = 0;
    nst  = 0;
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (last_ready != 4'b0000) nrdy++;
      if (last_start) nst++;
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if (m_idle) break;
      cycle();
      if (last_ready != 4'b0000) nrdy++;
      if (last_start) nst++;
    end
    nbusy = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (last_ready != 4'b0000) nrdy++;
      if (last_start) nst++;
      if (last_busy) nbusy++;
    end
    chk("pulse_ready", 32'(nrdy), 32'd0);
    chk("pulse_start", 32'(nst), 32'd0);
    chk("pulse_busy", 32'(nbusy), 32'd0);

    // Asynchronous reset 30 cycles into WAIT; rr_ptr must return to 0.
    req_data  = 32'hC3C3C3C3;
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0000;
    for (int c = 0; c < START_HOLD + 30; c++) cycle();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("post_rst_ready", 32'(last_ready), 32'b0001);
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    req_valid = 4'b0000;
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        req_valid = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
        req_data  = $urandom;
      end
      cycle();
    end
    req_valid = 4'b0000;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_send` transmitter between 4 requesters; each requester offers one byte per handshake.
- Round-robin arbitration picks a winner and latches its byte.
- The block drives the transmitter's data bus and start input (rising-edge triggered), holding the data stable for a full frame.
- The transmitter has no busy output, so the frame length is timed internally from the same baud parameters. The block sits between the application byte sources and the UART TX path.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 9600, baud rate; must match the transmitter. Derived BPS_CNT = CLK_FREQ/UART_BPS.
- START_HOLD, 4, number of cycles tx_start is held high per frame (≥3, so the transmitter's 2-flop edge detector sees it).
- GUARD_CYCLES, 16, idle cycles added after 10*BPS_CNT before the next grant (≥8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  4  per-requester byte-available flag.
- req_data  in  32  bytes; requester i uses bits [8i+7:8i].
- req_ready  out  4  one-hot accept strobe; a transfer happens when req_valid[i] and req_ready[i] are both high at a clk edge.
- tx_data  out  8  byte to the transmitter, held stable for the whole frame.
- tx_start  out  1  start to the transmitter (rising edge starts a frame).
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  2  index of the last accepted requester.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state = IDLE; tx_start = 0; tx_data = 8'h00; grant_id = 0; rr_ptr = 0; all counters = 0.
  - busy = 0; req_ready = 0.
  - A frame in flight is abandoned; the transmitter's own reset handles the line.
- States: IDLE, START, WAIT. The encoding is free; there is no unreachable-state lockup, and default goes to IDLE.
- IDLE:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo 4.
  - req_ready = onehot(winner) combinationally, only in IDLE and only when some req_valid is high; otherwise 4'b0000.
  - At the edge where a winner exists: tx_data <= the winner's byte; grant_id <= winner; rr_ptr <= winner+1 (mod 4, 2-bit wrap); hold counter cleared; go to START.
- START:
  - tx_start = 1 for exactly START_HOLD cycles, then go to WAIT with the frame counter cleared.
- WAIT:
  - tx_start = 0. The frame counter counts 10*BPS_CNT + GUARD_CYCLES cycles, then the state returns to IDLE.
  - The counter is wide enough for this total (≥20 bits at the defaults; the total is 52096).
- Timing:
  - Acceptance at edge T gives tx_start high in cycles T+1 … T+START_HOLD.
  - The next possible acceptance is at edge T + 1 + START_HOLD + 10*BPS_CNT + GUARD_CYCLES.
  - tx_data only changes at an acceptance edge.
- Requester rules:
  - The requester holds req_valid and its byte until ready is seen.
  - Deasserting valid before acceptance withdraws the request; no frame is sent.
  - req_valid high while busy is simply ignored; there is no queueing.
- Simultaneous requests: exactly one grant per frame. A requester that is continuously valid is served within 4 frames.
- tx_start always returns low for at least one full WAIT before the next rising edge, so every frame produces a distinct edge.

Optional Feature:
- UART_ARB_PRIO0_EN defined:
  - Requester 0 has absolute priority: if req_valid[0] is high in IDLE, it wins regardless of rr_ptr.
  - Requesters 1–3 rotate round-robin among themselves; rr_ptr is only updated when a requester 1–3 wins.
- Undefined: pure 4-way round-robin as described above.

Test Plan (CLK_FREQ=1000, UART_BPS=100 → BPS_CNT=10, frame=100+16):
- Reset, then req_valid=4'b0010, byte1=8'hA5 → req_ready=4'b0010 for one cycle. Next cycle: tx_data=8'hA5, grant_id=1, tx_start high 4 cycles, busy high. Busy drops 121 cycles after acceptance. Paired with `uart_send`, the line shows 0,1,0,1,0,0,1,0,1,1 (LSB first).
- All four valid continuously with bytes 8'h10/8'h11/8'h12/8'h13 → grants in order 0,1,2,3,0; each tx_data is correct; acceptance spacing is exactly 121 cycles.
- req_valid[2] pulsed during WAIT and dropped before IDLE → no req_ready[2], no extra tx_start, busy falls and stays low.
- rst_n asserted 30 cycles into WAIT → immediately tx_start=0, tx_data=8'h00, busy=0, rr_ptr=0. After release, valid=4'b1001 → requester 0 is granted.
- With UART_ARB_PRIO0_EN, all four valid continuously → grants 0,0,0…; drop req_valid[0] → grants 1,2,3,1.
- Check that tx_start never rises twice within 121 cycles and that tx_data is constant for the whole busy window (assertions).
